spmv_row_mac_8: RTL and testbench



---
 rtl/spmv_row_mac_8.sv | 240 ++++++++++++++++++++++++
 tb/tb_spmv_row_mac_8.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spmv_row_mac_8.sv
`default_nettype none
// ============================================================================
//  Module      : spmv_row_mac_8
//  Description : Row multiply-accumulate stage of the sparse matrix-vector
//                multiply datapath. Each beat multiplies 8 gathered vector
//                elements by 8 matrix nonzeros lane-wise in signed fixed point,
//                reduces the products with a two-level adder tree, accumulates
//                across all chunks of a row and emits one saturated result
//                per row, tagged with a running row index.
//                Pipeline: S1 multiply/shift, S2 partial sums, S3 accumulate,
//                S4 clamp and report. The last beat at T reports at T+4.
//  Revision    : 1.0  initial release
// ============================================================================
module spmv_row_mac_8 #(
    parameter int NO_OF_UNITS   = 8,
    parameter int ELEMENT_WIDTH = 32,
    parameter int FRAC_BITS     = 16,
    parameter int ACC_WIDTH     = 48
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   vec_in,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   val_in,
    input  logic                                   in_valid,
    input  logic [31:0]                            no_of_multiples,
    output logic [ELEMENT_WIDTH-1:0]               row_result,
    output logic                                   result_valid,
    output logic [31:0]                            row_index,
    output logic                                   sat_flag,
    output logic                                   busy
);

    // The full-precision product is kept at least as wide as the accumulator
    // so the final size cast either truncates or sign-extends correctly.
    localparam int PROD_W = 2 * ELEMENT_WIDTH;
    localparam int WIDE_W = (PROD_W > ACC_WIDTH) ? PROD_W : ACC_WIDTH;
    localparam int HALF   = NO_OF_UNITS / 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Control FSM state and beat tags
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [31:0] n_q;
    logic [31:0] chunk_cnt_q;

    logic [31:0] n_eff_d;
    logic [31:0] cnt_inc_d;
    logic        beat_first_d;
    logic        beat_last_d;

    // Tag the incoming beat as first/last of its row from the current FSM state
    always_comb begin
        n_eff_d      = (no_of_multiples == 32'd0) ? 32'd1 : no_of_multiples;
        cnt_inc_d    = chunk_cnt_q + 32'd1;
        beat_first_d = (state_q == IDLE);
        if (state_q == IDLE) begin
            beat_last_d = (n_eff_d == 32'd1);
        end else begin
            beat_last_d = (cnt_inc_d == n_q);
        end
    end

    // Row chunk counter FSM; a row length of 0 behaves as 1
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= 32'd0;
            chunk_cnt_q <= 32'd0;
        end else if (in_valid) begin
            case (state_q)
                IDLE: begin
                    n_q <= n_eff_d;
                    if (n_eff_d != 32'd1) begin
                        chunk_cnt_q <= 32'd1;
                        state_q     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (cnt_inc_d == n_q) begin
                        chunk_cnt_q <= 32'd0;
                        state_q     <= IDLE;
                    end else begin
                        chunk_cnt_q <= cnt_inc_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // S1: lane-wise signed multiply, rescale to the fixed-point grid
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] lane_prod_d [NO_OF_UNITS];
    logic signed [ACC_WIDTH-1:0] s1_prod_q   [NO_OF_UNITS];
    logic                        s1_valid_q, s1_first_q, s1_last_q;

    generate
        for (genvar g = 0; g < NO_OF_UNITS; g++) begin : g_lane
            logic signed [ELEMENT_WIDTH-1:0] a_w;
            logic signed [ELEMENT_WIDTH-1:0] b_w;
            logic signed [WIDE_W-1:0]        full_w;
            assign a_w    = vec_in[g*ELEMENT_WIDTH +: ELEMENT_WIDTH];
            assign b_w    = val_in[g*ELEMENT_WIDTH +: ELEMENT_WIDTH];
            assign full_w = a_w * b_w;
            // Arithmetic shift floors toward minus infinity
            assign lane_prod_d[g] = ACC_WIDTH'(full_w >>> FRAC_BITS);
        end
    endgenerate

    // S1 control: valid and row tags travel alongside the products
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            s1_first_q <= beat_first_d;
            s1_last_q  <= beat_last_d;
        end
    end

    // S1 data: product registers carry no reset, qualified by s1_valid_q
    always_ff @(posedge clk) begin
        for (int i = 0; i < NO_OF_UNITS; i++) begin
            s1_prod_q[i] <= lane_prod_d[i];
        end
    end

    // ------------------------------------------------------------------
    // S2: two half-width partial sums (wrapping at ACC_WIDTH)
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] p_hi_d, p_lo_d, p_hi_q, p_lo_q;
    logic                        s2_valid_q, s2_first_q, s2_last_q;

    // Upper lanes feed p_hi, lower lanes feed p_lo
    always_comb begin
        p_hi_d = '0;
        p_lo_d = '0;
        for (int i = 0; i < HALF; i++) begin
            p_lo_d = p_lo_d + s1_prod_q[i];
            p_hi_d = p_hi_d + s1_prod_q[i+HALF];
        end
    end

    // S2 registers for partial sums and tags
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            p_hi_q     <= '0;
            p_lo_q     <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            p_hi_q     <= p_hi_d;
            p_lo_q     <= p_lo_d;
        end
    end

    // ------------------------------------------------------------------
    // S3: chunk sum and row accumulation
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] chunk_d, acc_d, acc_q;
    logic                        s3_valid_q, s3_last_q;

    // A first beat restarts the accumulator so back-to-back rows need no bubble
    always_comb begin
        chunk_d = p_hi_q + p_lo_q;
        acc_d   = s2_first_q ? chunk_d : (acc_q + chunk_d);
    end

    // Accumulator update on valid beats only; gaps hold the partial row
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
        end else begin
            if (s2_valid_q) begin
                acc_q <= acc_d;
            end
            s3_valid_q <= s2_valid_q;
            s3_last_q  <= s2_valid_q & s2_last_q;
        end
    end

    // ------------------------------------------------------------------
    // S4: clamp to the element range and report
    // ------------------------------------------------------------------
    logic                     sat_d;
    logic [ELEMENT_WIDTH-1:0] result_d;
    logic [31:0]              row_cnt_q;
    logic                     report_d;

    // The value fits when every bit above the element sign bit matches it
    always_comb begin
        report_d = s3_valid_q & s3_last_q;
        sat_d    = !((&acc_q[ACC_WIDTH-1:ELEMENT_WIDTH-1]) ||
                     (~|acc_q[ACC_WIDTH-1:ELEMENT_WIDTH-1]));
        if (!sat_d) begin
            result_d = acc_q[ELEMENT_WIDTH-1:0];
        end else if (acc_q[ACC_WIDTH-1]) begin
            result_d = {1'b1, {(ELEMENT_WIDTH-1){1'b0}}};
        end else begin
            result_d = {1'b0, {(ELEMENT_WIDTH-1){1'b1}}};
        end
    end

    // Result registers; row_index holds the index of the reported row
    always_ff @(posedge clk) begin
        if (rst) begin
            row_result   <= '0;
            result_valid <= 1'b0;
            row_index    <= 32'd0;
            sat_flag     <= 1'b0;
            row_cnt_q    <= 32'd0;
        end else begin
            result_valid <= report_d;
            if (report_d) begin
                row_result <= result_d;
                sat_flag   <= sat_d;
                row_index  <= row_cnt_q;
                row_cnt_q  <= row_cnt_q + 32'd1;
            end
        end
    end

    assign busy = (state_q == ACCUM) | s1_valid_q | s2_valid_q | s3_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spmv_row_mac_8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spmv_row_mac_8
//  Description : Scoreboard bench for spmv_row_mac_8. Stimulus pushes the
//                expected row result when it issues a row's last beat; a
//                monitor pops and compares on every result_valid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spmv_row_mac_8;

    localparam int NU = 8;
    localparam int EW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NU*EW-1:0]  vec_in, val_in;
    logic              in_valid;
    logic [31:0]       no_of_multiples;
    logic [EW-1:0]     row_result;
    logic              result_valid;
    logic [31:0]       row_index;
    logic              sat_flag;
    logic              busy;

    spmv_row_mac_8 dut (
        .clk             (clk),
        .rst             (rst),
        .vec_in          (vec_in),
        .val_in          (val_in),
        .in_valid        (in_valid),
        .no_of_multiples (no_of_multiples),
        .row_result      (row_result),
        .result_valid    (result_valid),
        .row_index       (row_index),
        .sat_flag        (sat_flag),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [31:0] idx;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_idx = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%08h expected no pulse", row_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("row_result", row_result, e.res);
                chk("row_index", row_index, e.idx);
                chk("sat_flag", {31'd0, sat_flag}, {31'd0, e.sat});
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Place a beat on the inputs at the current negedge; the last beat of a
    // row books its expected result four cycles later.
    task automatic set_beat(input logic [31:0] v, input logic [31:0] w, input logic [31:0] n,
                            input bit last, input logic [31:0] res, input bit sat);
        vec_in          = {NU{v}};
        val_in          = {NU{w}};
        no_of_multiples = n;
        in_valid        = 1'b1;
        if (last) begin
            exp_t e;
            e.res = res;
            e.idx = exp_idx;
            e.sat = sat;
            e.cyc = cyc + 4;
            sb.push_back(e);
            exp_idx = exp_idx + 32'd1;
        end
    endtask

    task automatic beat(input logic [31:0] v, input logic [31:0] w, input logic [31:0] n,
                        input bit last, input logic [31:0] res, input bit sat);
        @(negedge clk);
        set_beat(v, w, n, last, res, sat);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            in_valid = 1'b0;
            vec_in   = '0;
            val_in   = '0;
        end
    endtask

    // Wait (bounded) until every booked result has been seen
    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        idle(2);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        in_valid        = 1'b0;
        vec_in          = '0;
        val_in          = '0;
        no_of_multiples = 32'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_row_result", row_result, 32'h0);
        chk("reset_result_valid", {31'd0, result_valid}, 32'h0);
        chk("reset_row_index", row_index, 32'h0);
        chk("reset_sat_flag", {31'd0, sat_flag}, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;

        // Single-chunk row at cycle 10: 8 x (1.0*2.0) = 16.0
        while (cyc < 10) @(negedge clk);
        set_beat(32'h0001_0000, 32'h0002_0000, 32'd1, 1'b1, 32'h0010_0000, 1'b0);
        idle(1);
        drain();

        // Three-chunk row, beats at rel 0,2,5; busy must cover rel 1..8
        for (int rel = 0; rel <= 9; rel++) begin
            @(negedge clk);
            chk($sformatf("busy_rel%0d", rel), {31'd0, busy},
                (rel >= 1 && rel <= 8) ? 32'd1 : 32'd0);
            if (rel == 0 || rel == 2 || rel == 5) begin
                set_beat(32'h0000_8000, 32'h0001_0000, (rel == 0) ? 32'd3 : 32'd77,
                         rel == 5, 32'h000C_0000, 1'b0);
            end else begin
                in_valid = 1'b0;
            end
        end
        drain();

        // Back-to-back single-chunk rows
        beat(32'h0001_0000, 32'h0001_0000, 32'd1, 1'b1, 32'h0008_0000, 1'b0);
        beat(32'hFFFF_0000, 32'h0001_0000, 32'd1, 1'b1, 32'hFFF8_0000, 1'b0);
        beat(32'h0003_0000, 32'h0001_0000, 32'd1, 1'b1, 32'h0018_0000, 1'b0);
        beat(32'h0000_0000, 32'h0001_0000, 32'd1, 1'b1, 32'h0000_0000, 1'b0);
        idle(1);
        drain();

        // Positive and negative saturation over two chunks
        beat(32'h7FFF_0000, 32'h0002_0000, 32'd2, 1'b0, 32'h0, 1'b0);
        beat(32'h7FFF_0000, 32'h0002_0000, 32'd2, 1'b1, 32'h7FFF_FFFF, 1'b1);
        beat(32'h8001_0000, 32'h0002_0000, 32'd2, 1'b0, 32'h0, 1'b0);
        beat(32'h8001_0000, 32'h0002_0000, 32'd2, 1'b1, 32'h8000_0000, 1'b1);
        idle(1);
        drain();

        // Row length 0 behaves as 1
        beat(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 32'h0008_0000, 1'b0);
        idle(1);
        drain();

        // Reset mid-row: partial row discarded, index restarts at 0
        beat(32'h0001_0000, 32'h0001_0000, 32'd4, 1'b0, 32'h0, 1'b0);
        beat(32'h0001_0000, 32'h0001_0000, 32'd4, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        exp_idx  = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        chk("post_reset_busy", {31'd0, busy}, 32'h0);
        beat(32'h0001_0000, 32'h0001_0000, 32'd1, 1'b1, 32'h0008_0000, 1'b0);
        idle(1);
        drain();
        idle(6);
        chk("final_busy", {31'd0, busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
